simd_mac_pipe: RTL and testbench

//  Multi-lane, 3-stage pipelined fixed-point multiply / MAC unit for the SIMD datapath.
//  Per lane: signed multiply, rescale to destination Q-format, round-half-up, saturate.

---
 rtl/simd_mac_pipe_pkg.sv | 49 ++++
 rtl/simd_mac_pipe_if.sv | 36 +++
 rtl/simd_mac_pipe_lane.sv | 109 ++++++++++
 rtl/simd_mac_pipe.sv | 79 +++++++
 tb/tb_simd_mac_pipe.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_mac_pipe_pkg.sv
// Shared opcode/function codes, pipeline sideband types and the
// saturation / rescale-shift helpers for the SIMD MAC pipe.
package simd_mac_pipe_pkg;

    localparam int OP_ARITH = 0;
    localparam int OP_ACT   = 1;
    localparam int FN_LRELU = 1;
    localparam int FN_MUL   = 2;
    localparam int FN_MACC  = 3;
    localparam int FN_ACC   = 4;

    localparam int SH_W   = 6;
    // Wide enough for a 2x32-bit product plus rounding and accumulate headroom.
    localparam int CALC_W = 72;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef enum logic [2:0] {
        OPS_MUL,
        OPS_MACC,
        OPS_ACC,
        OPS_LRELU,
        OPS_PASS
    } op_sel_e;

    typedef struct packed {
        op_sel_e         op;
        logic            first;
        logic [SH_W-1:0] sh;
    } beat_cfg_t;

    function automatic calc_t sat_max(input int w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t sat_min(input int w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    function automatic logic [SH_W-1:0] clamp_sh(input int w, input logic [7:0] dest,
                                                 input logic [7:0] src1, input logic [7:0] src2);
        int sh;
        sh = w - int'(src1) - int'(src2) + int'(dest);
        if (sh < 0) sh = 0;
        else if (sh > w) sh = w;
        return SH_W'(sh);
    endfunction

endpackage

// File: rtl/simd_mac_pipe_if.sv
// Input/output beat bundle of the SIMD MAC pipe; master drives operands
// and out_ready, slave returns results.
interface simd_mac_pipe_if #(
    parameter int NUM_LANES     = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int OPCODE_BITS   = 4,
    parameter int FUNCTION_BITS = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_first;
    logic [OPCODE_BITS-1:0]         opcode;
    logic [FUNCTION_BITS-1:0]       fn;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_in0;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_in1;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_acc;
    logic [7:0]                     dest_integer_bits;
    logic [7:0]                     src1_integer_bits;
    logic [7:0]                     src2_integer_bits;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_out;
    logic [NUM_LANES-1:0]           sat_out;

    modport master (
        output in_valid, in_first, opcode, fn, data_in0, data_in1, data_acc,
               dest_integer_bits, src1_integer_bits, src2_integer_bits, out_ready,
        input  in_ready, out_valid, data_out, sat_out
    );

    modport slave (
        input  in_valid, in_first, opcode, fn, data_in0, data_in1, data_acc,
               dest_integer_bits, src1_integer_bits, src2_integer_bits, out_ready,
        output in_ready, out_valid, data_out, sat_out
    );
endinterface

// File: rtl/simd_mac_pipe_lane.sv
// One lane of the MAC datapath: multiply, rescale/round/saturate, then the
// per-function result select and the lane's running accumulator.
module simd_mac_pipe_lane
    import simd_mac_pipe_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_en,
    input  logic signed [BIT_WIDTH-1:0] i_a,
    input  logic signed [BIT_WIDTH-1:0] i_b,
    input  logic signed [BIT_WIDTH-1:0] i_add,
    input  logic [SH_W-1:0]             i_s2_sh,
    input  logic                        i_s3_valid,
    input  op_sel_e                     i_s3_op,
    input  logic                        i_s3_first,
    output logic signed [BIT_WIDTH-1:0] o_data,
    output logic                        o_sat
);
    localparam int    PW   = 2 * BIT_WIDTH;
    localparam calc_t MAXV = sat_max(BIT_WIDTH);
    localparam calc_t MINV = sat_min(BIT_WIDTH);

    // Returns {clipped, value}.
    function automatic logic [BIT_WIDTH:0] clip(input calc_t v);
        if (v > MAXV) return {1'b1, MAXV[BIT_WIDTH-1:0]};
        if (v < MINV) return {1'b1, MINV[BIT_WIDTH-1:0]};
        return {1'b0, v[BIT_WIDTH-1:0]};
    endfunction

    logic signed [BIT_WIDTH-1:0] r_a1, r_add1, r_a2, r_add2, r_m2, r_acc, r_out;
    logic signed [PW-1:0]        r_p1;
    logic                        r_sat2, r_sat;

    calc_t                       w_rnd, w_m2, w_m3, w_macc, w_accsum;
    logic [BIT_WIDTH:0]          w_clip2, w_clip3;
    logic signed [BIT_WIDTH-1:0] w_out;
    logic                        w_sat3;

    assign w_rnd    = (i_s2_sh == '0) ? '0 : (calc_t'(1) <<< (i_s2_sh - SH_W'(1)));
    assign w_m2     = (calc_t'(r_p1) + w_rnd) >>> i_s2_sh;
    assign w_clip2  = clip(w_m2);
    assign w_m3     = calc_t'(r_m2);
    assign w_macc   = w_m3 + calc_t'(r_add2);
    assign w_accsum = (i_s3_first ? '0 : calc_t'(r_acc)) + w_m3;

    always_comb begin
        w_out   = r_a2;
        w_sat3  = 1'b0;
        w_clip3 = '0;
        case (i_s3_op)
            OPS_MUL: begin
                w_out  = r_m2;
                w_sat3 = r_sat2;
            end
            OPS_MACC: begin
                w_clip3 = clip(w_macc);
                w_out   = w_clip3[BIT_WIDTH-1:0];
                w_sat3  = r_sat2 | w_clip3[BIT_WIDTH];
            end
            OPS_ACC: begin
                w_clip3 = clip(w_accsum);
                w_out   = w_clip3[BIT_WIDTH-1:0];
                w_sat3  = r_sat2 | w_clip3[BIT_WIDTH];
            end
            OPS_LRELU: begin
                if (r_a2[BIT_WIDTH-1]) begin
                    w_out  = r_m2;
                    w_sat3 = r_sat2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a1   <= '0;
            r_add1 <= '0;
            r_p1   <= '0;
            r_a2   <= '0;
            r_add2 <= '0;
            r_m2   <= '0;
            r_sat2 <= 1'b0;
            r_out  <= '0;
            r_sat  <= 1'b0;
            r_acc  <= '0;
        end else if (i_en) begin
            r_a1   <= i_a;
            r_add1 <= i_add;
            r_p1   <= PW'(i_a) * PW'(i_b);
            r_a2   <= r_a1;
            r_add2 <= r_add1;
            r_m2   <= w_clip2[BIT_WIDTH-1:0];
            r_sat2 <= w_clip2[BIT_WIDTH];
            // Bubbles leave the output and accumulator untouched.
            if (i_s3_valid) begin
                r_out <= w_out;
                r_sat <= w_sat3;
                if (i_s3_op == OPS_ACC) r_acc <= w_out;
            end
        end
    end

    assign o_data = r_out;
    assign o_sat  = r_sat;

endmodule

// File: rtl/simd_mac_pipe.sv
// 3-stage SIMD fixed-point MUL/MACC/ACC/leaky-ReLU pipe: owns the valid
// chain, the stall handshake and the per-beat config sideband.
module simd_mac_pipe
    import simd_mac_pipe_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int OPCODE_BITS   = 4,
    parameter int FUNCTION_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    simd_mac_pipe_if.slave   bus
);
    logic                           w_en, w_accept;
    beat_cfg_t                      w_cfg;
    logic                           r_v1, r_v2, r_out_valid;
    beat_cfg_t                      r_cfg1, r_cfg2;
    logic [NUM_LANES*BIT_WIDTH-1:0] w_data_out;
    logic [NUM_LANES-1:0]           w_sat_out;

    // All stages move together; a full output register that is not taken stalls everything.
    assign w_en         = ~r_out_valid | bus.out_ready;
    assign w_accept     = bus.in_valid & w_en;
    assign bus.in_ready = w_en;

    always_comb begin
        w_cfg.first = bus.in_first;
        w_cfg.sh    = clamp_sh(BIT_WIDTH, bus.dest_integer_bits,
                               bus.src1_integer_bits, bus.src2_integer_bits);
        w_cfg.op    = OPS_PASS;
        if (bus.opcode == OPCODE_BITS'(OP_ARITH)) begin
            if (bus.fn == FUNCTION_BITS'(FN_MUL))       w_cfg.op = OPS_MUL;
            else if (bus.fn == FUNCTION_BITS'(FN_MACC)) w_cfg.op = OPS_MACC;
            else if (bus.fn == FUNCTION_BITS'(FN_ACC))  w_cfg.op = OPS_ACC;
        end else if (bus.opcode == OPCODE_BITS'(OP_ACT) &&
                     bus.fn == FUNCTION_BITS'(FN_LRELU)) begin
            w_cfg.op = OPS_LRELU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_cfg1      <= '0;
            r_cfg2      <= '0;
        end else if (w_en) begin
            r_v1        <= w_accept;
            r_cfg1      <= w_cfg;
            r_v2        <= r_v1;
            r_cfg2      <= r_cfg1;
            r_out_valid <= r_v2;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        simd_mac_pipe_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_en       (w_en),
            .i_a        (bus.data_in0[g*BIT_WIDTH +: BIT_WIDTH]),
            .i_b        (bus.data_in1[g*BIT_WIDTH +: BIT_WIDTH]),
            .i_add      (bus.data_acc[g*BIT_WIDTH +: BIT_WIDTH]),
            .i_s2_sh    (r_cfg1.sh),
            .i_s3_valid (r_v2),
            .i_s3_op    (r_cfg2.op),
            .i_s3_first (r_cfg2.first),
            .o_data     (w_data_out[g*BIT_WIDTH +: BIT_WIDTH]),
            .o_sat      (w_sat_out[g])
        );
    end

    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = w_data_out;
    assign bus.sat_out   = w_sat_out;

endmodule

// File: tb/tb_simd_mac_pipe.sv
// Scoreboard bench for simd_mac_pipe at 4 lanes x 16 bits with directed,
// hand-computed vectors; a monitor pops expected beats as results appear.
module tb_simd_mac_pipe;
    localparam int NL = 4;
    localparam int W  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    simd_mac_pipe_if #(.NUM_LANES(NL), .BIT_WIDTH(W), .OPCODE_BITS(4), .FUNCTION_BITS(4)) bus ();

    simd_mac_pipe #(.NUM_LANES(NL), .BIT_WIDTH(W), .OPCODE_BITS(4), .FUNCTION_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [67:0] exp_q[$];
    bit          bp_on  = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] fn, input logic first,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] add,
                        input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [63:0] exp_d, input logic [3:0] exp_s);
        int t = 0;
        bit done = 1'b0;
        @(negedge clk);
        bus.opcode            = op;
        bus.fn                = fn;
        bus.in_first          = first;
        bus.data_in0          = a;
        bus.data_in1          = b;
        bus.data_acc          = add;
        bus.dest_integer_bits = d;
        bus.src1_integer_bits = s1;
        bus.src2_integer_bits = s2;
        bus.in_valid          = 1'b1;
        while (!done) begin
            #1;
            if (bus.in_ready) begin
                exp_q.push_back({exp_s, exp_d});
                @(posedge clk);
                done = 1'b1;
            end else begin
                t++;
                if (t > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready stayed %b, need 1", bus.in_ready);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still pending, need 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Output-side backpressure: ready pattern 1,0,0,1 while enabled.
    initial begin
        bit [3:0] pat = 4'b1001;
        int idx = 0;
        forever begin
            @(negedge clk);
            if (bp_on) begin
                bus.out_ready = pat[idx];
                idx = (idx + 1) % 4;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: compare every transferred beat; results must hold while stalled.
    initial begin
        logic        stalled = 1'b0;
        logic [63:0] held_d  = '0;
        logic [3:0]  held_s  = '0;
        logic [67:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (bus.data_out !== held_d || bus.sat_out !== held_s) begin
                        errors++;
                        $display("FAIL stall_hold: data %h sat %b, held data %h sat %b",
                                 bus.data_out, bus.sat_out, held_d, held_s);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: data %h with empty scoreboard, need no beat",
                                 bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.data_out !== e[63:0] || bus.sat_out !== e[67:64]) begin
                            errors++;
                            $display("FAIL beat: data %h sat %b, expected data %h sat %b",
                                     bus.data_out, bus.sat_out, e[63:0], e[67:64]);
                        end
                    end
                    stalled = 1'b0;
                end else if (bus.out_valid) begin
                    stalled = 1'b1;
                    held_d  = bus.data_out;
                    held_s  = bus.sat_out;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        int          lat;
        logic [15:0] base;
        logic [63:0] va;
        bus.in_valid          = 1'b0;
        bus.in_first          = 1'b0;
        bus.opcode            = '0;
        bus.fn                = '0;
        bus.data_in0          = '0;
        bus.data_in1          = '0;
        bus.data_acc          = '0;
        bus.dest_integer_bits = 8'd8;
        bus.src1_integer_bits = 8'd8;
        bus.src2_integer_bits = 8'd8;
        bus.out_ready         = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data_out", bus.data_out, 64'd0);
        chk("rst_sat_out", 64'(bus.sat_out), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // MUL incl. negation, saturation both sides and the exact minimum
        send(4'd0, 4'd2, 1'b0, 64'h8000_7F00_FE80_0180, 64'h0100_7F00_0200_0200, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h8000_7FFF_FD00_0300, 4'b0100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        drain();

        // back-to-back: negative clip, rounding, MACC, leaky-ReLU, pass-through, formats
        send(4'd0, 4'd2, 1'b0, 64'h0200_FFFF_0001_8100, 64'hFE00_0080_0080_7F00, 64'd0,
             8'd8, 8'd8, 8'd8, 64'hFC00_0000_0001_8000, 4'b0001);
        send(4'd0, 4'd3, 1'b0, 64'h7F00_8000_7000_0100, 64'h7F00_0100_0100_0200,
             64'h8000_FF00_2000_0150, 8'd8, 8'd8, 8'd8, 64'hFFFF_8000_7FFF_0350, 4'b1110);
        send(4'd1, 4'd1, 1'b0, 64'h0000_8000_0200_FF00, 64'h1234_7F00_0020_0020, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0000_8000_0200_FFE0, 4'b0100);
        send(4'd1, 4'd2, 1'b0, 64'hFFFF_8000_1234_7F00, 64'h7F00_7F00_7F00_7F00, 64'd0,
             8'd8, 8'd8, 8'd8, 64'hFFFF_8000_1234_7F00, 4'b0000);
        send(4'd0, 4'd7, 1'b0, 64'h0001_0002_0003_8000, 64'h7F00_7F00_7F00_7F00, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0001_0002_0003_8000, 4'b0000);
        send(4'd0, 4'd2, 1'b0, 64'h0001_F000_1000_0100, 64'h0001_0180_0300_0100, 64'd0,
             8'd8, 8'd4, 8'd8, 64'h0000_FE80_0300_0010, 4'b0000);
        send(4'd0, 4'd2, 1'b0, 64'h7FFF_00FF_0080_0100, 64'h7FFF_0080_0100_0100, 64'd0,
             8'd8, 8'd0, 8'd0, 64'h3FFF_0000_0001_0001, 4'b0000);
        send(4'd0, 4'd2, 1'b0, 64'h0200_0100_FFFF_0003, 64'hFFC0_0080_0005_0002, 64'd0,
             8'd0, 8'd16, 8'd16, 64'h8000_7FFF_FFFB_0006, 4'b0100);
        drain();

        // ACC: lane1 accumulates 0x7F00 per beat and pins at max; MUL in between is ignored
        send(4'd0, 4'd4, 1'b1, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0100_0100_7F00_0100, 4'b0000);
        send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0200_0200_7FFF_0200, 4'b0010);
        send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0300_0300_7FFF_0300, 4'b0010);
        send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0400_0400_7FFF_0400, 4'b0010);
        send(4'd0, 4'd2, 1'b0, 64'h8000_7F00_FE80_0180, 64'h0100_7F00_0200_0200, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h8000_7FFF_FD00_0300, 4'b0100);
        send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0500_0500_7FFF_0500, 4'b0010);
        send(4'd0, 4'd4, 1'b1, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0100_0100_7F00_0100, 4'b0000);
        drain();

        // backpressure: 8 streamed beats, B = 1.0 so each result equals A
        bp_on = 1'b1;
        for (int k = 0; k < 8; k++) begin
            base = 16'((k + 1) * 256);
            va   = {base + 16'd3, base + 16'd2, base + 16'd1, base};
            send(4'd0, 4'd2, 1'b0, va, 64'h0100_0100_0100_0100, 64'd0,
                 8'd8, 8'd8, 8'd8, va, 4'b0000);
        end
        drain();
        bp_on = 1'b0;

        // reset with acc = 0x0300 and three ACC beats in flight
        send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0200_0200_7FFF_0200, 4'b0010);
        send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0300_0300_7FFF_0300, 4'b0010);
        drain();
        for (int k = 0; k < 3; k++) begin
            base = 16'((k + 4) * 256);
            send(4'd0, 4'd4, 1'b0, 64'h0100_0100_0100_0100, 64'h0100_0100_7F00_0100, 64'd0,
                 8'd8, 8'd8, 8'd8, {base, base, 16'h7FFF, base}, 4'b0010);
        end
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data_out", bus.data_out, 64'd0);
        chk("mid_rst_sat_out", 64'(bus.sat_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        send(4'd0, 4'd4, 1'b0, 64'h0200_0200_0200_0200, 64'h0100_0100_0100_0100, 64'd0,
             8'd8, 8'd8, 8'd8, 64'h0200_0200_0200_0200, 4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
